// File: rtl/enc_bin2onehot_pipe.sv
// enc_bin2onehot_pipe
//   Pipelined binary-to-one-hot / thermometer decoder with a valid/ready
//   handshake on both sides. A main register (M) drives the outputs. A single
//   skid register (S) absorbs one extra word while the downstream stalls, so
//   in_ready depends only on registered state and rst.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream word valid
//   in_ready   block can accept (transfer on in_valid && in_ready)
//   in         binary code, unsigned, IN_W bits
//   in_mode    0 = one-hot, 1 = thermometer, sampled with in
//   out_valid  decoded word valid
//   out_ready  downstream accepts (transfer on out_valid && out_ready)
//   out        decoded word, OUT_W bits, zero while out_valid = 0
//   out_oor    word in out came from a code >= OUT_W
//   err_cnt    saturating count of accepted out-of-range codes
//   err_clr    synchronous clear of err_cnt (wins over a same-cycle increment)

module enc_bin2onehot_pipe #(
  parameter int IN_W      = 4,
  parameter int OUT_W     = 15,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out,
  output logic                 out_oor,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);

  // One extra bit so that OUT_W = 2^IN_W is representable and never flags.
  localparam logic [IN_W:0]      OUT_W_X = (IN_W+1)'(OUT_W);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic                 m_valid_q, m_valid_d;
  logic [OUT_W-1:0]     m_data_q,  m_data_d;
  logic                 m_oor_q,   m_oor_d;
  logic                 s_valid_q, s_valid_d;
  logic [OUT_W-1:0]     s_data_q,  s_data_d;
  logic                 s_oor_q,   s_oor_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [IN_W:0]        code_x;
  logic                 in_oor;
  logic [OUT_W-1:0]     dec;
  logic                 accept;
  logic                 drain;

  // Decoder
  always_comb begin
    code_x = {1'b0, in};
    in_oor = (code_x >= OUT_W_X);
    dec    = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (in_mode) dec[i] = ((IN_W+1)'(i) <= code_x);
      else         dec[i] = ((IN_W+1)'(i) == code_x);
    end
    // Thermometer would otherwise light every bit for an out-of-range code.
    if (in_oor) dec = '0;
  end

  assign in_ready = !rst && !s_valid_q;
  assign accept   = in_valid && in_ready;
  assign drain    = m_valid_q && out_ready;

  // M/S pipeline and error counter next-state
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_oor_d   = m_oor_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_oor_d   = s_oor_q;

    if (!m_valid_q || drain) begin
      if (s_valid_q) begin
        // in_ready is low here, so no accept can collide with the refill.
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        m_oor_d   = s_oor_q;
        s_valid_d = 1'b0;
        s_data_d  = '0;
        s_oor_d   = 1'b0;
      end else if (accept) begin
        m_valid_d = 1'b1;
        m_data_d  = dec;
        m_oor_d   = in_oor;
      end else begin
        // Keep out/out_oor at zero whenever out_valid is low.
        m_valid_d = 1'b0;
        m_data_d  = '0;
        m_oor_d   = 1'b0;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_data_d  = dec;
      s_oor_d   = in_oor;
    end

    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (accept && in_oor && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_oor_q   <= 1'b0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_oor_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_oor_q   <= m_oor_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_oor_q   <= s_oor_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid = m_valid_q;
  assign out       = m_data_q;
  assign out_oor   = m_oor_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_enc_bin2onehot_pipe.sv
module tb_enc_bin2onehot_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_code;
  logic        in_mode;
  logic        out_ready;
  logic        err_clr;

  // main instance: IN_W=4, OUT_W=15, ERR_CNT_W=8
  logic        in_ready, out_valid, out_oor;
  logic [14:0] out;
  logic [7:0]  err_cnt;
  // narrow counter instance: ERR_CNT_W=2
  logic        in_ready2, out_valid2, out_oor2;
  logic [14:0] out2;
  logic [1:0]  err_cnt2;
  // full-range instance: IN_W=3, OUT_W=8
  logic        in_ready3, out_valid3, out_oor3;
  logic [7:0]  out3;
  logic [7:0]  err_cnt3;

  always #5 clk = ~clk;

  enc_bin2onehot_pipe #(.IN_W(4), .OUT_W(15), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in(in_code), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .out_oor(out_oor),
    .err_cnt(err_cnt), .err_clr(err_clr));

  enc_bin2onehot_pipe #(.IN_W(4), .OUT_W(15), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in(in_code), .in_mode(in_mode), .out_valid(out_valid2),
    .out_ready(out_ready), .out(out2), .out_oor(out_oor2),
    .err_cnt(err_cnt2), .err_clr(err_clr));

  enc_bin2onehot_pipe #(.IN_W(3), .OUT_W(8), .ERR_CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .in(in_code[2:0]), .in_mode(in_mode), .out_valid(out_valid3),
    .out_ready(out_ready), .out(out3), .out_oor(out_oor3),
    .err_cnt(err_cnt3), .err_clr(err_clr));

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_dec(input int c, input int w, input bit m);
    if (c >= w) return 32'd0;
    if (m) return (32'd2 << c) - 32'd1;
    return 32'd1 << c;
  endfunction

  typedef struct {
    logic [14:0] o;
    logic        oor;
    logic [7:0]  o3;
  } exp_t;

  exp_t        sb[$];
  int          err_m  = 0;
  int          err2_m = 0;
  bit          hold_act = 0;
  logic [14:0] hold_val;

  // Scoreboard: push on accept, pop on drain (pre-edge values).
  always @(posedge clk) begin
    exp_t e;
    hold_act = 0;
    if (rst) begin
      sb.delete();
      err_m  = 0;
      err2_m = 0;
    end else begin
      if (out_valid && !out_ready) begin
        hold_act = 1;
        hold_val = out;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("out",   32'(out),      32'(e.o));
          chk("oor",   32'(out_oor),  32'(e.oor));
          chk("out3",  32'(out3),     32'(e.o3));
          chk("oor3",  32'(out_oor3), 32'd0);
        end
      end
      if (in_valid && in_ready) begin
        e.o   = 15'(ref_dec(int'(in_code), 15, in_mode));
        e.oor = (in_code >= 4'd15);
        e.o3  = 8'(ref_dec(int'(in_code[2:0]), 8, in_mode));
        sb.push_back(e);
        if (in_code >= 4'd15) begin
          if (err_m  < 255) err_m++;
          if (err2_m < 3)   err2_m++;
        end
      end
      if (err_clr) begin
        err_m  = 0;
        err2_m = 0;
      end
    end
  end

  // Per-cycle state checks, away from the active edge.
  always @(negedge clk) begin
    #1;
    chk("valid",   32'(out_valid),  32'(sb.size() != 0));
    chk("ready",   32'(in_ready),   32'(!rst && sb.size() < 2));
    chk("valid3",  32'(out_valid3), 32'(sb.size() != 0));
    chk("err_cnt", 32'(err_cnt),    32'(err_m));
    chk("err_cnt2", 32'(err_cnt2),  32'(err2_m));
    chk("err_cnt3", 32'(err_cnt3),  32'd0);
    if (!out_valid) begin
      chk("idle_out", 32'(out),     32'd0);
      chk("idle_oor", 32'(out_oor), 32'd0);
    end
    if (hold_act) chk("hold", 32'(out), 32'(hold_val));
  end

  task automatic send(input int c, input bit m);
    int g;
    @(negedge clk);
    in_valid = 1'b1;
    in_code  = 4'(c);
    in_mode  = m;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int sat_exp[5] = '{1, 2, 3, 3, 3};
    int th[4] = '{0, 3, 14, 15};

    rst = 1'b1; in_valid = 1'b0; in_code = '0; in_mode = 1'b0;
    out_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready),  32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1 chk("rst_ready_after", 32'(in_ready), 32'd1);

    // one-hot sweep 0..15
    for (int c = 0; c < 16; c++) begin
      send(c, 1'b0);
      #1;
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("lat_out", 32'(out), (c < 15) ? (32'd1 << c) : 32'd0);
    end
    idle(3);
    chk("sweep_err", 32'(err_cnt), 32'd1);

    // thermometer
    foreach (th[i]) send(th[i], 1'b1);
    idle(3);

    // backpressure: 5 and 6 accepted, 7 stalls
    @(negedge clk);
    out_ready = 1'b0;
    send(5, 1'b0);
    send(6, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_code = 4'd7; in_mode = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_hold",  32'(out),      32'h20);
    end
    out_ready = 1'b1;
    g = 0;
    while (!in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) chk("bp_timeout", 32'd0, 32'd1);
    @(posedge clk);
    idle(4);

    // saturation on the 2-bit counter
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(15, 1'b0);
      #1 chk("sat", 32'(err_cnt2), 32'(sat_exp[i]));
    end
    @(negedge clk);
    err_clr = 1'b1; in_valid = 1'b1; in_code = 4'd15;
    @(posedge clk);
    #1;
    chk("clr_win2", 32'(err_cnt2), 32'd0);
    chk("clr_win",  32'(err_cnt),  32'd0);
    @(negedge clk);
    err_clr = 1'b0;
    idle(3);

    // mid-stream reset with M and S full
    @(negedge clk);
    out_ready = 1'b0;
    send(2, 1'b1);
    send(15, 1'b0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_code = 4'd3;
    @(negedge clk);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_out",   32'(out),       32'd0);
    chk("mr_err",   32'(err_cnt),   32'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1 chk("mr_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("mr_no_stale", 32'(out_valid), 32'd0);

    // mixed-mode back-to-back words
    for (int c = 0; c < 8; c++) send(c, c[0]);
    idle(4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
